// File: rtl/binom_pkg.sv
`default_nettype none
// ============================================================================
// Module   : binom_pkg
// Brief    : Shared mode codes, FSM states and constants for the binomial feeder.
// Revision : 1.0 - initial release
// ============================================================================
package binom_pkg;

    typedef enum logic [2:0] {
        BINOM_MODE_K2 = 3'b000,
        BINOM_MODE_K3 = 3'b001,
        BINOM_MODE_K4 = 3'b010,
        BINOM_MODE_K5 = 3'b011,
        BINOM_MODE_K8 = 3'b100
    } binom_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } binom_state_t;

    localparam int BINOM_LANE_HI_OFS = 16;
    localparam int BINOM_MAX_K       = 8;
    localparam int BINOM_BUF_W       = 64;
    localparam int BINOM_CNT_W       = 7;

    // Codes outside the defined set fall back to the widest lane (k=8).
    function automatic logic [3:0] mode_to_k(input logic [2:0] mode);
        logic [3:0] k;
        case (mode)
            BINOM_MODE_K2: k = 4'd2;
            BINOM_MODE_K3: k = 4'd3;
            BINOM_MODE_K4: k = 4'd4;
            BINOM_MODE_K5: k = 4'd5;
            default:       k = 4'(BINOM_MAX_K);
        endcase
        return k;
    endfunction

endpackage
`default_nettype wire

// File: rtl/binom_bit_buf.sv
`default_nettype none
// ============================================================================
// Module   : binom_bit_buf
// Brief    : 64-bit LSB-oldest bit buffer with occupancy, push-32 / pop-4k.
// Revision : 1.0 - initial release
// ============================================================================
module binom_bit_buf #(
    parameter int WORD_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_clear,
    input  logic                   i_push,
    input  logic [WORD_W-1:0]      i_push_data,
    input  logic                   i_pop,
    input  logic [5:0]             i_pop_bits,
    output logic [63:0]            o_buf,
    output logic [6:0]             o_cnt
);
    import binom_pkg::*;

    logic [BINOM_BUF_W-1:0] r_buf;
    logic [BINOM_CNT_W-1:0] r_cnt;
    logic [BINOM_BUF_W-1:0] w_shifted;
    logic [BINOM_CNT_W-1:0] w_cnt_after;
    logic [BINOM_BUF_W-1:0] w_buf_nxt;
    logic [BINOM_CNT_W-1:0] w_cnt_nxt;

    // Bits at and above r_cnt are kept zero, so a push can simply OR in.
    always_comb begin
        w_shifted   = i_pop ? (r_buf >> i_pop_bits) : r_buf;
        w_cnt_after = i_pop ? (r_cnt - BINOM_CNT_W'(i_pop_bits)) : r_cnt;
        w_buf_nxt   = w_shifted;
        w_cnt_nxt   = w_cnt_after;
        if (i_push) begin
            w_buf_nxt = w_shifted | (BINOM_BUF_W'(i_push_data) << w_cnt_after);
            w_cnt_nxt = w_cnt_after + BINOM_CNT_W'(WORD_W);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_buf <= '0;
            r_cnt <= '0;
        end else if (i_clear) begin
            r_buf <= '0;
            r_cnt <= '0;
        end else begin
            r_buf <= w_buf_nxt;
            r_cnt <= w_cnt_nxt;
        end
    end

    assign o_buf = r_buf;
    assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/binom_bit_feeder.sv
`default_nettype none
// ============================================================================
// Module   : binom_bit_feeder
// Brief    : Repacks 32-bit random words into CBD sampler operand pairs.
//            Optional words_used_o counter enabled by BINOM_FEEDER_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module binom_bit_feeder #(
    parameter int WORD_W     = 32,
    parameter int BEAT_CNT_W = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [2:0]            mode_i,
    input  logic [BEAT_CNT_W-1:0] n_beats_i,
    input  logic                  rnd_valid_i,
    input  logic [WORD_W-1:0]     rnd_data_i,
    output logic                  rnd_ready_o,
    output logic                  smp_valid_o,
    output logic [31:0]           smp_in1_o,
    output logic [31:0]           smp_in2_o,
    output logic [2:0]            smp_mode_o,
    input  logic                  smp_ready_i,
    output logic                  busy_o,
    output logic                  done_o
`ifdef BINOM_FEEDER_CNT_EN
    ,
    output logic [31:0]           words_used_o
`endif
);
    import binom_pkg::*;

    localparam int NEED_W = BEAT_CNT_W + 6;

    binom_state_t            r_state;
    binom_state_t            w_state_nxt;
    logic [2:0]              r_mode;
    logic [5:0]              r_k;
    logic [BEAT_CNT_W-1:0]   r_beats_left;

    logic [BINOM_BUF_W-1:0]  w_buf;
    logic [BINOM_CNT_W-1:0]  w_cnt;
    logic [5:0]              w_pop_bits;
    logic [NEED_W-1:0]       w_need;
    logic                    w_start;
    logic                    w_clear;
    logic                    w_rnd_fire;
    logic                    w_smp_fire;

    logic [5:0]              w_ofs2;
    logic [5:0]              w_ofs3;
    logic [BINOM_MAX_K-1:0]  w_mask;
    logic [BINOM_MAX_K-1:0]  w_lane0;
    logic [BINOM_MAX_K-1:0]  w_lane1;
    logic [BINOM_MAX_K-1:0]  w_lane2;
    logic [BINOM_MAX_K-1:0]  w_lane3;

    assign w_start    = (r_state == ST_IDLE) && start_i;
    assign w_clear    = w_start || (r_state == ST_DONE);
    assign w_pop_bits = r_k << 2;

    // Bits still owed to the job; no word is requested once they are buffered.
    assign w_need = NEED_W'(r_beats_left) * NEED_W'(w_pop_bits);

    assign rnd_ready_o = (r_state == ST_RUN)
                      && (w_cnt <= BINOM_CNT_W'(WORD_W))
                      && (NEED_W'(w_cnt) < w_need);
    assign smp_valid_o = (r_state == ST_RUN) && (w_cnt >= BINOM_CNT_W'(w_pop_bits));
    assign w_rnd_fire  = rnd_ready_o && rnd_valid_i;
    assign w_smp_fire  = smp_valid_o && smp_ready_i;

    binom_bit_buf #(
        .WORD_W      (WORD_W)
    ) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (w_clear),
        .i_push      (w_rnd_fire),
        .i_push_data (rnd_data_i),
        .i_pop       (w_smp_fire),
        .i_pop_bits  (w_pop_bits),
        .o_buf       (w_buf),
        .o_cnt       (w_cnt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_state_nxt = (n_beats_i == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                busy_o = 1'b1;
                if (w_smp_fire && (r_beats_left == BEAT_CNT_W'(1))) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_o      = 1'b1;
                done_o      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mode       <= '0;
            r_k          <= '0;
            r_beats_left <= '0;
        end else if (w_start) begin
            r_mode       <= mode_i;
            r_k          <= 6'(mode_to_k(mode_i));
            r_beats_left <= n_beats_i;
        end else if (w_smp_fire) begin
            r_beats_left <= r_beats_left - BEAT_CNT_W'(1);
        end
    end

    // Four k-bit fields from the buffer LSBs, spread over low and high lanes.
    assign w_ofs2  = r_k << 1;
    assign w_ofs3  = r_k + w_ofs2;
    assign w_mask  = BINOM_MAX_K'((9'd1 << r_k) - 9'd1);
    assign w_lane0 = BINOM_MAX_K'(w_buf) & w_mask;
    assign w_lane1 = BINOM_MAX_K'(w_buf >> r_k) & w_mask;
    assign w_lane2 = BINOM_MAX_K'(w_buf >> w_ofs2) & w_mask;
    assign w_lane3 = BINOM_MAX_K'(w_buf >> w_ofs3) & w_mask;

    assign smp_in1_o  = 32'(w_lane0) | (32'(w_lane2) << BINOM_LANE_HI_OFS);
    assign smp_in2_o  = 32'(w_lane1) | (32'(w_lane3) << BINOM_LANE_HI_OFS);
    assign smp_mode_o = r_mode;

`ifdef BINOM_FEEDER_CNT_EN
    logic [31:0] r_words_used;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_words_used <= '0;
        end else if (w_rnd_fire && (r_words_used != 32'hFFFF_FFFF)) begin
            r_words_used <= r_words_used + 32'd1;
        end
    end

    assign words_used_o = r_words_used;
`endif

endmodule
`default_nettype wire

// File: tb/tb_binom_bit_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_binom_bit_feeder
// Brief    : Directed and randomized jobs checked against a bit-stream model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_binom_bit_feeder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [2:0]  mode_i;
    logic [8:0]  n_beats_i;
    logic        rnd_valid_i;
    logic [31:0] rnd_data_i;
    logic        rnd_ready_o;
    logic        smp_valid_o;
    logic [31:0] smp_in1_o;
    logic [31:0] smp_in2_o;
    logic [2:0]  smp_mode_o;
    logic        smp_ready_i;
    logic        busy_o;
    logic        done_o;
`ifdef BINOM_FEEDER_CNT_EN
    logic [31:0] words_used;
`endif

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] words[$];
    logic [31:0] first1, first2, last1, last2;

    always #5 clk = ~clk;

    binom_bit_feeder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .mode_i       (mode_i),
        .n_beats_i    (n_beats_i),
        .rnd_valid_i  (rnd_valid_i),
        .rnd_data_i   (rnd_data_i),
        .rnd_ready_o  (rnd_ready_o),
        .smp_valid_o  (smp_valid_o),
        .smp_in1_o    (smp_in1_o),
        .smp_in2_o    (smp_in2_o),
        .smp_mode_o   (smp_mode_o),
        .smp_ready_i  (smp_ready_i),
        .busy_o       (busy_o),
        .done_o       (done_o)
`ifdef BINOM_FEEDER_CNT_EN
        ,
        .words_used_o (words_used)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int k_of(input logic [2:0] mode);
        case (mode)
            3'd0: return 2;
            3'd1: return 3;
            3'd2: return 4;
            3'd3: return 5;
            default: return 8;
        endcase
    endfunction

    // Bit b of the concatenated random stream, word 0 first, LSB first.
    function automatic logic stream_bit(input int b);
        logic [31:0] w;
        w = words[b / 32];
        return w[b % 32];
    endfunction

    function automatic void exp_beat(input int j, input int k,
                                     output logic [31:0] e1, output logic [31:0] e2);
        int base;
        base = 4 * k * j;
        e1 = '0;
        e2 = '0;
        for (int i = 0; i < k; i++) begin
            e1[i]      = stream_bit(base + i);
            e2[i]      = stream_bit(base + k + i);
            e1[16 + i] = stream_bit(base + 2 * k + i);
            e2[16 + i] = stream_bit(base + 3 * k + i);
        end
    endfunction

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) words.push_back($urandom);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " rnd_ready"}, rnd_ready_o, 0);
        chk({tag, " smp_valid"}, smp_valid_o, 0);
        chk({tag, " in1"},       smp_in1_o,   0);
        chk({tag, " in2"},       smp_in2_o,   0);
        chk({tag, " mode"},      smp_mode_o,  0);
        chk({tag, " busy"},      busy_o,      0);
        chk({tag, " done"},      done_o,      0);
    endtask

    task automatic run_job(input logic [2:0] mode, input int nbeats, input int rdy_pct,
                           input int vld_pct, input int bp_cycles, input int abort_after,
                           input string tag);
        int k, need_words, widx, beats, mcnt, rem_bits, bp_left;
        bit exp_done, bp_started, finished;
        logic [31:0] e1, e2;
        k          = k_of(mode);
        need_words = (nbeats * 4 * k + 31) / 32;
        widx       = 0;
        beats      = 0;
        bp_left    = 0;
        bp_started = 0;
        finished   = 0;

        start_i     = 1'b1;
        mode_i      = mode;
        n_beats_i   = 9'(nbeats);
        rnd_valid_i = 1'b0;
        smp_ready_i = 1'b0;
        @(posedge clk); #1;
        start_i = 1'b0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (abort_after >= 0 && beats == abort_after) begin
                rst_n       = 1'b0;
                rnd_valid_i = 1'b0;
                smp_ready_i = 1'b0;
                @(posedge clk); #1;
                chk_all_zero({tag, " after reset"});
                rst_n = 1'b1;
                return;
            end
            mcnt     = 32 * widx - 4 * k * beats;
            rem_bits = 4 * k * (nbeats - beats);
            exp_done = (beats == nbeats);
            chk({tag, " done"},      done_o,      exp_done);
            chk({tag, " busy"},      busy_o,      1);
            chk({tag, " smp_valid"}, smp_valid_o, !exp_done && mcnt >= 4 * k);
            chk({tag, " rnd_ready"}, rnd_ready_o, !exp_done && mcnt <= 32 && mcnt < rem_bits);
            chk({tag, " mode"},      smp_mode_o,  mode);
            if (exp_done) begin
                finished = 1;
                break;
            end

            start_i     = 1'($urandom);
            mode_i      = 3'($urandom);
            n_beats_i   = 9'($urandom);
            rnd_valid_i = (widx < words.size()) && ($urandom_range(99) < vld_pct);
            rnd_data_i  = rnd_valid_i ? words[widx] : $urandom;
            if (smp_valid_o && !bp_started) begin
                bp_started = 1;
                bp_left    = bp_cycles;
            end
            smp_ready_i = (bp_left > 0) ? 1'b0 : ($urandom_range(99) < rdy_pct);
            if (bp_left > 0) bp_left--;

            if (smp_valid_o) begin
                exp_beat(beats, k, e1, e2);
                chk({tag, " in1"}, smp_in1_o, e1);
                chk({tag, " in2"}, smp_in2_o, e2);
                if (beats == 0) begin
                    first1 = smp_in1_o;
                    first2 = smp_in2_o;
                end
                if (beats == nbeats - 1) begin
                    last1 = smp_in1_o;
                    last2 = smp_in2_o;
                end
                if (smp_ready_i) beats++;
            end
            if (rnd_ready_o && rnd_valid_i) widx++;
            @(posedge clk); #1;
        end

        if (!finished) chk({tag, " beats before timeout"}, beats, nbeats + 1);
        chk({tag, " words used"}, widx, need_words);

        start_i     = 1'b0;
        rnd_valid_i = 1'b0;
        smp_ready_i = 1'b0;
        @(posedge clk); #1;
        chk({tag, " idle done"},  done_o,      0);
        chk({tag, " idle busy"},  busy_o,      0);
        chk({tag, " idle valid"}, smp_valid_o, 0);
        chk({tag, " idle ready"}, rnd_ready_o, 0);
        chk({tag, " idle in1"},   smp_in1_o,   0);
        chk({tag, " idle in2"},   smp_in2_o,   0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        start_i     = 1'b0;
        mode_i      = '0;
        n_beats_i   = '0;
        rnd_valid_i = 1'b0;
        rnd_data_i  = '0;
        smp_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // k=2 layout
        words.delete();
        words.push_back(32'h0000_00E4);
        fill_random(1);
        run_job(3'b000, 1, 100, 100, 0, -1, "k2");
        chk("k2 first in1", first1, 32'h0002_0000);
        chk("k2 first in2", first2, 32'h0003_0001);

        // k=8 layout, full-rate stream
        words.delete();
        words.push_back(32'h4433_2211);
        words.push_back(32'h8877_6655);
        fill_random(1);
        run_job(3'b100, 2, 100, 100, 0, -1, "k8");
        chk("k8 first in1", first1, 32'h0033_0011);
        chk("k8 first in2", first2, 32'h0044_0022);
        chk("k8 last in1",  last1,  32'h0077_0055);
        chk("k8 last in2",  last2,  32'h0088_0066);

        // k=3 boundary: exactly three words
        words.delete();
        fill_random(4);
        run_job(3'b001, 8, 100, 100, 0, -1, "k3");

        // Backpressure with an eager source
        words.delete();
        fill_random(8);
        run_job(3'b010, 12, 70, 100, 5, -1, "bp");

        // Zero beats
        words.delete();
        fill_random(2);
        run_job(3'b011, 0, 100, 100, 0, -1, "zero");

        // Reset mid-job, then a fresh job
        words.delete();
        fill_random(8);
        run_job(3'b011, 10, 100, 100, 0, 3, "abort");
        words.delete();
        fill_random(8);
        run_job(3'b011, 10, 80, 80, 0, -1, "fresh");

        // Randomized jobs
        for (int j = 0; j < 8; j++) begin
            int nb;
            logic [2:0] md;
            md = 3'($urandom_range(7));
            nb = $urandom_range(40, 1);
            words.delete();
            fill_random(nb + 2);
            run_job(md, nb, $urandom_range(100, 30), $urandom_range(100, 30),
                    $urandom_range(6), -1, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/binom_bit_feeder.md
# binom_bit_feeder

Stream repacker that sits between the pseudo-random word source (Keccak/PRNG output) and the combinational centered-binomial sampler. It consumes a 32-bit random word stream and, for the selected parameter set, emits operand pairs `in_1`/`in_2` with exactly the bit layout the sampler expects. Each output beat yields two coefficients. The block carries a start/done job FSM that counts output beats and discards leftover random bits at job end.

## Interface
Parameters
- `WORD_W`, default 32: random input word width; only 32 is supported.
- `BEAT_CNT_W`, default 9: width of the beat-count field.

Ports
- `clk`, input, 1: clock.
- `rst_n`, input, 1: synchronous, active-low reset.
- `start_i`, input, 1: job start pulse. Ignored unless in IDLE.
- `mode_i`, input, 3: parameter set, sampled on start. `000` gives k=2, `001` k=3, `010` k=4, `011` k=5, any other value k=8.
- `n_beats_i`, input, `BEAT_CNT_W`: number of output beats in the job, sampled on start.
- `rnd_valid_i`, input, 1: random word valid.
- `rnd_data_i`, input, 32: random word.
- `rnd_ready_o`, output, 1: random word accepted when high together with valid.
- `smp_valid_o`, output, 1: operand pair valid.
- `smp_in1_o`, output, 32: operand `in_1` for the sampler.
- `smp_in2_o`, output, 32: operand `in_2` for the sampler.
- `smp_mode_o`, output, 3: latched mode, forwarded to the sampler.
- `smp_ready_i`, input, 1: downstream accepts the pair.
- `busy_o`, output, 1: high in RUN and DONE.
- `done_o`, output, 1: one-cycle pulse at job completion.

## Operation
- **Buffer.** 64-bit bit buffer `buf`, LSB oldest, with occupancy `cnt` (0..64).
- **Output consumption.** Each output beat consumes 4k bits from the LSB end of `buf`:
  - `in_1[k-1:0]` = `buf[k-1:0]`
  - `in_2[k-1:0]` = `buf[2k-1:k]`
  - `in_1[16+k-1:16]` = `buf[3k-1:2k]`
  - `in_2[16+k-1:16]` = `buf[4k-1:3k]`
  - All other operand bits are 0.
- **FSM states:**
  - **IDLE.** On `start_i`: latch mode, k and `n_beats`; clear `buf`/`cnt`; go to RUN. If `n_beats_i` = 0, go directly to DONE.
  - **RUN.**
    - `rnd_ready_o` = (`cnt` ≤ 32).
    - `smp_valid_o` = (`cnt` ≥ 4k).
    - The remaining-beat counter decrements on each output fire.
    - The last fire transitions to DONE.
  - **DONE.** `done_o` = 1 for one cycle; residual bits are discarded (`cnt` ← 0); next state is IDLE.
- **Simultaneous input and output fire.**
  - `cnt_next = cnt − 4k + 32`.
  - The new word is written at bit offset `cnt − 4k` of the shifted buffer.
  - `cnt` never exceeds 64 and never goes negative.
- **Latched values.** Mode and k are constant for the whole job; `mode_i` changes outside IDLE have no effect.
- **Handshake rules.**
  - Operands are held stable while `smp_valid_o` is high and `smp_ready_i` is low.
  - Valid is never withdrawn without a fire.
- **Reset.** Synchronous reset mid-job aborts it: state IDLE, `cnt` = 0, remaining beats = 0.

## Timing
- All outputs are reset to 0: `rnd_ready_o`, `smp_valid_o`, `smp_in1_o`, `smp_in2_o`, `smp_mode_o`, `busy_o`, `done_o`.
- Operands are driven combinationally from the registered `buf`. The cleared bits are therefore 0 in IDLE.
- A word accepted in cycle t contributes to `smp_valid_o` in cycle t+1.
- First beat after start: no earlier than cycle start+2 (start → RUN at t+1, word accepted at t+1, valid at t+2).
- Sustained throughput: one beat per cycle for k ≤ 8 while words arrive each cycle (k=8: 32 bits in, 32 bits out).
- `done_o` asserts the cycle after the last output fire.

## Configuration
- Macro: `BINOM_FEEDER_CNT_EN`.
- **Defined:** adds output `words_used_o` (32 bits), counting random words accepted since reset. It is not cleared by start, saturates at 0xFFFF_FFFF, and resets to 0.
- **Undefined:** the port and counter are absent; no other behaviour changes.

## Structure
- Shared package `binom_pkg` holds:
  - the `binom_mode_t` enum for the 3-bit mode codes;
  - the function `mode_to_k` (mode → k);
  - the constants `BINOM_LANE_HI_OFS` = 16 and `BINOM_MAX_K` = 8.
- One sub-module, `binom_bit_buf`: the 64-bit buffer plus occupancy with push-32/pop-4k ports. The FSM and beat counter stay in the top level.

## Test plan
- **k=2 layout.** Mode `000`, `n_beats`=1, word `0x0000_00E4`. Expect `in_1`=`0x0002_0000`, `in_2`=`0x0003_0001`, `smp_mode_o`=`000`, then `done_o` one cycle later.
- **k=8 layout.** Mode `100`, `n_beats`=2, words `0x4433_2211`, `0x8877_6655`. Expect pairs (`0x0033_0011`, `0x0044_0022`) then (`0x0077_0055`, `0x0088_0066`).
- **k=3 boundary.** Mode `001`, `n_beats`=8, 3 words. Expect exactly 8 beats, `rnd_ready_o` never blocking the 3rd word, `cnt`=0 at DONE, and no 4th word requested.
- **Backpressure.** `smp_ready_i` held low for 5 cycles with valid high. Expect operands unchanged, `rnd_ready_o` low once `cnt` > 32, and no bit loss when resumed (compare against a bit-serial model).
- **Zero beats.** `n_beats_i`=0. Expect `done_o` at start+1, `smp_valid_o` never high, `rnd_ready_o` never high.
- **Reset mid-job.** `rst_n` low for one cycle after 3 beats of a 10-beat k=5 job. Expect all outputs 0 next cycle and a subsequent fresh job correct from its first word.
